pipeline_timer_bank: RTL

Parametrised memory-mapped timer bank on the pipeline CPU data bus. It replaces the single fixed TH/TL/TCON timer with NUM_TIMERS independent channels. Each channel adds a prescaler, a one-shot mode and a write-1-to-clear interrupt status. Interrupts are combined into one irqout line for the CPU, plus a per-channel vector.

---
 rtl/pipeline_timer_bank.sv | 113 +++++++++++
 1 files changed

// File: rtl/pipeline_timer_bank.sv
// Memory-mapped bank of NUM_TIMERS reloadable up-counters, each with a prescaler,
// one-shot mode and write-1-to-clear pending status, combined into one interrupt line.
module pipeline_timer_bank #(
    parameter int unsigned NUM_TIMERS = 4,
    parameter int unsigned WIDTH      = 32,
    parameter logic [31:0] BASE_ADDR  = 32'h40000100,
    parameter int unsigned PSC_W      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           Addr,
    input  logic [31:0]           WriteData,
    input  logic                  MemRd,
    input  logic                  MemWr,
    output logic [31:0]           ReadData,
    output logic                  irqout,
    output logic [NUM_TIMERS-1:0] irq_vec
);

    logic [WIDTH-1:0]      th_q   [NUM_TIMERS];
    logic [WIDTH-1:0]      tl_q   [NUM_TIMERS];
    logic [PSC_W-1:0]      psc_q  [NUM_TIMERS];
    logic [PSC_W-1:0]      pcnt_q [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] en_q, irq_en_q, oneshot_q, pend_q;

    logic [29:0]           word_off;
    logic                  aligned, gstat_sel;
    logic [1:0]            reg_sel;
    logic [NUM_TIMERS-1:0] ch_sel, tick, ovf;
    logic [NUM_TIMERS-1:0] wr_th, wr_tl, wr_tcon, wr_stat;

    // Word offset from the bank base; wraps to a huge value below BASE_ADDR so it never decodes.
    assign word_off  = Addr[31:2] - BASE_ADDR[31:2];
    assign aligned   = (Addr[1:0] == 2'b00);
    assign reg_sel   = word_off[1:0];
    assign gstat_sel = aligned && (word_off == 30'(4 * NUM_TIMERS));

    always_comb begin
        for (int c = 0; c < NUM_TIMERS; c++) begin
            ch_sel[c]  = aligned && (word_off[29:2] == 28'(c));
            tick[c]    = en_q[c] && (pcnt_q[c] == psc_q[c]);
            ovf[c]     = tick[c] && (tl_q[c] == {WIDTH{1'b1}});
            wr_th[c]   = MemWr && ch_sel[c] && (reg_sel == 2'd0);
            wr_tl[c]   = MemWr && ch_sel[c] && (reg_sel == 2'd1);
            wr_tcon[c] = MemWr && ch_sel[c] && (reg_sel == 2'd2);
            wr_stat[c] = MemWr && ch_sel[c] && (reg_sel == 2'd3);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NUM_TIMERS; c++) begin
                th_q[c]   <= '0;
                tl_q[c]   <= '0;
                psc_q[c]  <= '0;
                pcnt_q[c] <= '0;
            end
            en_q      <= '0;
            irq_en_q  <= '0;
            oneshot_q <= '0;
            pend_q    <= '0;
        end else begin
            for (int c = 0; c < NUM_TIMERS; c++) begin
                if (wr_th[c]) th_q[c] <= WriteData[WIDTH-1:0];

                if (wr_tl[c])      tl_q[c] <= WriteData[WIDTH-1:0];
                else if (ovf[c])   tl_q[c] <= th_q[c];
                else if (tick[c])  tl_q[c] <= tl_q[c] + WIDTH'(1);

                if (wr_tcon[c]) begin
                    en_q[c]      <= WriteData[0];
                    irq_en_q[c]  <= WriteData[1];
                    oneshot_q[c] <= WriteData[2];
                    psc_q[c]     <= WriteData[8 +: PSC_W];
                    pcnt_q[c]    <= '0;
                end else begin
                    if (ovf[c] && oneshot_q[c]) en_q[c] <= 1'b0;
                    pcnt_q[c] <= (!en_q[c] || tick[c]) ? '0 : pcnt_q[c] + PSC_W'(1);
                end

                // Overflow wins against a same-edge clear so no event is lost.
                if (ovf[c])                             pend_q[c] <= 1'b1;
                else if (wr_stat[c] && WriteData[0])    pend_q[c] <= 1'b0;
            end
        end
    end

    always_comb begin
        ReadData = '0;
        if (MemRd) begin
            if (gstat_sel) ReadData[NUM_TIMERS-1:0] = pend_q;
            for (int c = 0; c < NUM_TIMERS; c++) begin
                if (ch_sel[c]) begin
                    case (reg_sel)
                        2'd0: ReadData[WIDTH-1:0] = th_q[c];
                        2'd1: ReadData[WIDTH-1:0] = tl_q[c];
                        2'd2: begin
                            ReadData[0]          = en_q[c];
                            ReadData[1]          = irq_en_q[c];
                            ReadData[2]          = oneshot_q[c];
                            ReadData[8 +: PSC_W] = psc_q[c];
                        end
                        default: ReadData[0] = pend_q[c];
                    endcase
                end
            end
        end
    end

    assign irq_vec = pend_q & irq_en_q;
    assign irqout  = |irq_vec;

endmodule
